// File: rtl/uart_pkg.sv
// Shared register map, bus response codes and STATUS/CTRL bit positions
// for the memory-mapped byte FIFO block.
package uart_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  // Register select is addr[3:2]: 0x00, 0x04, 0x08, 0x0C.
  typedef enum logic [1:0] {
    REG_TXDATA = 2'b00,
    REG_RXDATA = 2'b01,
    REG_STATUS = 2'b10,
    REG_CTRL   = 2'b11
  } reg_sel_e;

  localparam int ST_TX_FULL  = 16;
  localparam int ST_TX_EMPTY = 17;
  localparam int ST_RX_FULL  = 18;
  localparam int ST_RX_EMPTY = 19;

  localparam int CTRL_IRQ_RX_EN = 0;
  localparam int CTRL_IRQ_TX_EN = 1;
  localparam int CTRL_TX_FLUSH  = 2;
  localparam int CTRL_RX_FLUSH  = 3;

  localparam int RXDATA_VALID_BIT = 31;

endpackage

// File: rtl/simple_sync_fifo.sv
// Synchronous FIFO with simultaneous push/pop, flush priority and a
// head output that reads zero while empty.
module simple_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk_i,
  input  logic                       arst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [WIDTH-1:0]           head_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == {CW{1'b0}});
  assign count_o = count_q;
  assign head_o  = empty_o ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

  // A full FIFO rejects a push even when a pop frees a slot this cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {WIDTH{1'b0}};
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/simple_if_fifo_regs.sv
// Memory-mapped TX/RX byte FIFO register block behind the simple bus bridge.
// Define SIMPLE_IF_FIFO_IRQ_EN to enable CTRL interrupt enables and irq_o.
module simple_if_fifo_regs
  import uart_pkg::*;
#(
  parameter int MEM_SIZE   = 32,
  parameter int DW         = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                mem_we_i,
  input  logic [MEM_SIZE-1:0] mem_waddr_i,
  input  logic [DW-1:0]       mem_wdata_i,
  input  logic [DW/8-1:0]     mem_wstrb_i,
  output logic [1:0]          mem_wresp_o,
  input  logic                mem_re_i,
  input  logic [MEM_SIZE-1:0] mem_raddr_i,
  output logic [DW-1:0]       mem_rdata_o,
  output logic [1:0]          mem_rresp_o,
  output logic [7:0]          tx_data_o,
  output logic                tx_valid_o,
  input  logic                tx_ready_i,
  input  logic [7:0]          rx_data_i,
  input  logic                rx_valid_i,
  output logic                rx_ready_o,
  output logic                irq_o
);
  localparam int CW = $clog2(FIFO_DEPTH+1);

  logic [CW-1:0] tx_count, rx_count;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic [7:0]    rx_head;
  logic          tx_push, tx_pop, tx_flush, rx_push, rx_pop, rx_flush;
  logic          waddr_ok, raddr_ok;
  logic [1:0]    ctrl_q, ctrl_d;
  logic          irq_q, irq_d;
  logic          unused_ok;

  assign unused_ok = &{1'b0, mem_wdata_i, mem_wstrb_i};

  assign waddr_ok = (mem_waddr_i[1:0] == 2'b00) && (mem_waddr_i[MEM_SIZE-1:4] == '0);
  assign raddr_ok = (mem_raddr_i[1:0] == 2'b00) && (mem_raddr_i[MEM_SIZE-1:4] == '0);

  assign tx_valid_o = ~tx_empty;
  assign tx_pop     = ~tx_empty & tx_ready_i;
  assign rx_ready_o = ~rx_full;
  assign rx_push    = rx_valid_i & ~rx_full;
  assign irq_o      = irq_q;

  simple_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk_i, .arst_i,
    .push_i(tx_push), .push_data_i(mem_wdata_i[7:0]), .pop_i(tx_pop), .flush_i(tx_flush),
    .count_o(tx_count), .full_o(tx_full), .empty_o(tx_empty), .head_o(tx_data_o)
  );

  simple_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk_i, .arst_i,
    .push_i(rx_push), .push_data_i(rx_data_i), .pop_i(rx_pop), .flush_i(rx_flush),
    .count_o(rx_count), .full_o(rx_full), .empty_o(rx_empty), .head_o(rx_head)
  );

  always_comb begin
    mem_wresp_o = RESP_OKAY;
    tx_push     = 1'b0;
    tx_flush    = 1'b0;
    rx_flush    = 1'b0;
    ctrl_d      = ctrl_q;
    if (mem_we_i && !waddr_ok) begin
      mem_wresp_o = RESP_DECERR;
    end else if (mem_we_i) begin
      case (reg_sel_e'(mem_waddr_i[3:2]))
        REG_TXDATA: begin
          if (mem_wstrb_i[0] && tx_full) begin
            mem_wresp_o = RESP_SLVERR;
          end else begin
            tx_push = mem_wstrb_i[0];
          end
        end
        REG_CTRL: begin
          if (mem_wstrb_i[0]) begin
`ifdef SIMPLE_IF_FIFO_IRQ_EN
            ctrl_d = mem_wdata_i[1:0];
`endif
            tx_flush = mem_wdata_i[CTRL_TX_FLUSH];
            rx_flush = mem_wdata_i[CTRL_RX_FLUSH];
          end else begin
            ctrl_d = ctrl_q;
          end
        end
        default: mem_wresp_o = RESP_OKAY;
      endcase
    end else begin
      mem_wresp_o = RESP_OKAY;
    end
  end

  // STATUS reports pre-edge FIFO state; an RXDATA read pops only when data exists.
  always_comb begin
    mem_rdata_o = {DW{1'b0}};
    mem_rresp_o = RESP_OKAY;
    rx_pop      = 1'b0;
    if (mem_re_i && !raddr_ok) begin
      mem_rresp_o = RESP_DECERR;
    end else if (mem_re_i) begin
      case (reg_sel_e'(mem_raddr_i[3:2]))
        REG_RXDATA: begin
          if (!rx_empty) begin
            mem_rdata_o[RXDATA_VALID_BIT] = 1'b1;
            mem_rdata_o[7:0]              = rx_head;
            rx_pop                        = 1'b1;
          end else begin
            rx_pop = 1'b0;
          end
        end
        REG_STATUS: begin
          mem_rdata_o[7:0]         = 8'(tx_count);
          mem_rdata_o[15:8]        = 8'(rx_count);
          mem_rdata_o[ST_TX_FULL]  = tx_full;
          mem_rdata_o[ST_TX_EMPTY] = tx_empty;
          mem_rdata_o[ST_RX_FULL]  = rx_full;
          mem_rdata_o[ST_RX_EMPTY] = rx_empty;
        end
        REG_CTRL: mem_rdata_o[1:0] = ctrl_q;
        default:  mem_rdata_o = {DW{1'b0}};
      endcase
    end else begin
      mem_rresp_o = RESP_OKAY;
    end
  end

  always_comb begin
`ifdef SIMPLE_IF_FIFO_IRQ_EN
    irq_d = (ctrl_q[CTRL_IRQ_RX_EN] & ~rx_empty) | (ctrl_q[CTRL_IRQ_TX_EN] & tx_empty);
`else
    irq_d = 1'b0;
`endif
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      ctrl_q <= 2'b00;
      irq_q  <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      irq_q  <= irq_d;
    end
  end

endmodule
